// File: rtl/buf_req_ctrl.sv
// Request front-end for the 4-entry buffer pool: tag lookup, free fill,
// and LFU-directed replacement with a single request in flight.
module buf_req_ctrl #(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_buf,
  output logic             rsp_hit,
  output logic             evict_valid,
  output logic [TAG_W-1:0] evict_tag,
  output logic             ref_valid,
  output logic [1:0]       ref_buf_numbr,
  output logic             new_buf_req,
  input  logic [1:0]       buf_num_replc
);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REPL_REQ,
    REPL_WAIT,
    RESP
  } state_t;

  state_t           state;
  logic [TAG_W-1:0] tags [4];
  logic [3:0]       vld;
  logic [TAG_W-1:0] cur;
  logic [TAG_W-1:0] evict_hold;

  logic       hit;
  logic [1:0] hit_idx;
  logic       free;
  logic [1:0] free_idx;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = 2'd0;
    free     = 1'b0;
    free_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (vld[i] && tags[i] == cur) begin
        hit     = 1'b1;
        hit_idx = 2'(i);
      end
      if (!vld[i]) begin
        free     = 1'b1;
        free_idx = 2'(i);
      end
    end
  end

  assign req_ready   = (state == IDLE) && !flush;
  // The victim index is only valid during REPL_WAIT, so the eviction
  // report has to be visible in that same cycle.
  assign evict_valid = (state == REPL_WAIT);
  assign evict_tag   = evict_valid ? tags[buf_num_replc]
                                   : evict_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      vld           <= '0;
      for (int i = 0; i < 4; i++)
        tags[i] <= '0;
      cur           <= '0;
      evict_hold    <= '0;
      rsp_valid     <= 1'b0;
      rsp_buf       <= 2'd0;
      rsp_hit       <= 1'b0;
      ref_valid     <= 1'b0;
      ref_buf_numbr <= 2'd0;
      new_buf_req   <= 1'b0;
    end else begin
      ref_valid   <= 1'b0;
      new_buf_req <= 1'b0;
      unique case (state)
        IDLE: begin
          if (flush) begin
            vld <= '0;
          end else if (req_valid) begin
            cur   <= req_tag;
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          unique case (1'b1)
            hit: begin
              state         <= RESP;
              rsp_valid     <= 1'b1;
              rsp_buf       <= hit_idx;
              rsp_hit       <= 1'b1;
              ref_valid     <= 1'b1;
              ref_buf_numbr <= hit_idx;
            end
            (!hit && free): begin
              tags[free_idx] <= cur;
              vld[free_idx]  <= 1'b1;
              state          <= RESP;
              rsp_valid      <= 1'b1;
              rsp_buf        <= free_idx;
              rsp_hit        <= 1'b0;
              ref_valid      <= 1'b1;
              ref_buf_numbr  <= free_idx;
            end
            default: begin
              state       <= REPL_REQ;
              new_buf_req <= 1'b1;
            end
          endcase
        end
        REPL_REQ: begin
          state <= REPL_WAIT;
        end
        REPL_WAIT: begin
          evict_hold          <= tags[buf_num_replc];
          tags[buf_num_replc] <= cur;
          state               <= RESP;
          rsp_valid           <= 1'b1;
          rsp_buf             <= buf_num_replc;
          rsp_hit             <= 1'b0;
          ref_valid           <= 1'b1;
          ref_buf_numbr       <= buf_num_replc;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buf_req_ctrl.sv
// Directed bench for buf_req_ctrl: expectations queued at request time,
// compared when the response handshake arrives.
module tb_buf_req_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_tag;
  logic       flush;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_buf;
  logic       rsp_hit;
  logic       evict_valid;
  logic [7:0] evict_tag;
  logic       ref_valid;
  logic [1:0] ref_buf_numbr;
  logic       new_buf_req;
  logic [1:0] buf_num_replc;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] b;
    logic       hit;
    int         lat;
    int         nreq;
    int         nev;
    logic [7:0] evt;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  buf_req_ctrl #(.TAG_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_tag(req_tag),
    .flush(flush),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_buf(rsp_buf),
    .rsp_hit(rsp_hit),
    .evict_valid(evict_valid),
    .evict_tag(evict_tag),
    .ref_valid(ref_valid),
    .ref_buf_numbr(ref_buf_numbr),
    .new_buf_req(new_buf_req),
    .buf_num_replc(buf_num_replc)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_outs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_evict_valid"}, 32'(evict_valid), 32'd0);
    chk({tag, "_ref_valid"}, 32'(ref_valid), 32'd0);
    chk({tag, "_new_buf_req"}, 32'(new_buf_req), 32'd0);
  endtask

  // One full request/response; hold = cycles rsp_ready stays low.
  task automatic req(input string tag, input logic [7:0] t,
                     input logic [1:0] victim, input int hold,
                     input exp_t e);
    int lat;
    int nreq;
    int nev;
    int nref;
    logic [7:0] evt;
    logic [1:0] b0;
    exp_t x;
    sb.push_back(e);
    @(negedge clk);
    req_valid     = 1'b1;
    req_tag       = t;
    buf_num_replc = victim;
    #1;
    chk({tag, "_accept"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    lat  = 1;
    nreq = 0;
    nev  = 0;
    nref = 0;
    evt  = 8'h00;
    while (!rsp_valid && lat < 12) begin
      if (new_buf_req) nreq++;
      if (evict_valid) begin
        nev++;
        evt = evict_tag;
      end
      if (ref_valid) nref++;
      chk({tag, "_busy"}, 32'(req_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    x = sb.pop_front();
    chk({tag, "_latency"}, 32'(lat), 32'(x.lat));
    chk({tag, "_rsp_buf"}, 32'(rsp_buf), 32'(x.b));
    chk({tag, "_rsp_hit"}, 32'(rsp_hit), 32'(x.hit));
    chk({tag, "_ref_first"}, 32'(ref_valid), 32'd1);
    chk({tag, "_ref_buf"}, 32'(ref_buf_numbr), 32'(x.b));
    chk({tag, "_new_buf_req_n"}, 32'(nreq), 32'(x.nreq));
    chk({tag, "_evict_n"}, 32'(nev), 32'(x.nev));
    if (x.nev != 0) begin
      chk({tag, "_evict_tag"}, 32'(evt), 32'(x.evt));
      chk({tag, "_evict_hold"}, 32'(evict_tag), 32'(x.evt));
    end
    b0 = rsp_buf;
    if (ref_valid) nref++;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (ref_valid) nref++;
      chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_buf"}, 32'(rsp_buf), 32'(b0));
      chk({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (ref_valid) nref++;
    chk({tag, "_ref_once"}, 32'(nref), 32'd1);
    chk({tag, "_rsp_done"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_back_idle"}, 32'(req_ready), 32'd1);
  endtask

  function automatic exp_t mk(input logic [1:0] b, input logic hit,
                              input int lat, input int nreq,
                              input int nev, input logic [7:0] evt);
    exp_t e;
    e.b    = b;
    e.hit  = hit;
    e.lat  = lat;
    e.nreq = nreq;
    e.nev  = nev;
    e.evt  = evt;
    return e;
  endfunction

  initial begin
    int seen;
    rst_n         = 1'b0;
    req_valid     = 1'b0;
    req_tag       = 8'h00;
    flush         = 1'b0;
    rsp_ready     = 1'b0;
    buf_num_replc = 2'd0;
    #12;
    idle_outs("reset");
    chk("reset_rsp_buf", 32'(rsp_buf), 32'd0);
    chk("reset_ref_buf", 32'(ref_buf_numbr), 32'd0);
    chk("reset_evict_tag", 32'(evict_tag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill from empty, then hit.
    req("t1_11", 8'h11, 2'd0, 0, mk(2'd0, 1'b0, 2, 0, 0, 8'h00));
    req("t2_22", 8'h22, 2'd0, 0, mk(2'd1, 1'b0, 2, 0, 0, 8'h00));
    req("t2_33", 8'h33, 2'd0, 0, mk(2'd2, 1'b0, 2, 0, 0, 8'h00));
    req("t2_44", 8'h44, 2'd0, 0, mk(2'd3, 1'b0, 2, 0, 0, 8'h00));
    req("t2_22h", 8'h22, 2'd0, 1, mk(2'd1, 1'b1, 2, 0, 0, 8'h00));

    // Replacement through the LFU.
    req("t3_55", 8'h55, 2'd2, 0, mk(2'd2, 1'b0, 4, 1, 1, 8'h33));
    req("t3_55h", 8'h55, 2'd0, 0, mk(2'd2, 1'b1, 2, 0, 0, 8'h00));

    // Back-pressure on the response.
    req("t4_44h", 8'h44, 2'd0, 5, mk(2'd3, 1'b1, 2, 0, 0, 8'h00));

    // Flush wins over a simultaneous request.
    @(negedge clk);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_tag   = 8'h99;
    #1;
    chk("t5_flush_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    #1;
    idle_outs("t5_after");
    @(negedge clk);
    chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
    req("t5_11", 8'h11, 2'd0, 0, mk(2'd0, 1'b0, 2, 0, 0, 8'h00));
    req("t5_22", 8'h22, 2'd0, 0, mk(2'd1, 1'b0, 2, 0, 0, 8'h00));
    req("t5_33", 8'h33, 2'd0, 0, mk(2'd2, 1'b0, 2, 0, 0, 8'h00));
    req("t5_44", 8'h44, 2'd0, 0, mk(2'd3, 1'b0, 2, 0, 0, 8'h00));

    // Reset while waiting for the victim.
    @(negedge clk);
    req_valid     = 1'b1;
    req_tag       = 8'h77;
    buf_num_replc = 2'd1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("t6_new_buf_req", 32'(new_buf_req), 32'd1);
    @(negedge clk);
    chk("t6_evict_valid", 32'(evict_valid), 32'd1);
    chk("t6_evict_tag", 32'(evict_tag), 32'h22);
    rst_n = 1'b0;
    #1;
    idle_outs("t6_rst");
    chk("t6_rst_rsp_buf", 32'(rsp_buf), 32'd0);
    chk("t6_rst_evict_tag", 32'(evict_tag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid || evict_valid || ref_valid) seen++;
    end
    chk("t6_quiet", 32'(seen), 32'd0);
    req("t6_77", 8'h77, 2'd0, 0, mk(2'd0, 1'b0, 2, 0, 0, 8'h00));
    req("t6_22", 8'h22, 2'd0, 0, mk(2'd1, 1'b0, 2, 0, 0, 8'h00));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
